adder_arbiter: RTL and testbench

- Shares one signed_adder instance (SIZE-bit operands, SIZE+1-bit result) between two requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin grant; one operation in flight at a time; operands and results are registered.
- Sits between the ALU front-end issue logic and the shared adder datapath.

---
 rtl/adder_arbiter.sv | 128 ++++++++++++
 tb/tb_adder_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one signed_adder; one operation in flight, registered operands/results.
// Optional build macro ADDER_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties) instead of round-robin.

module signed_adder #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE:0]   result,
    output logic            overflow
);
    // Sign-extended sum; overflow flags a sum that does not fit back into SIZE signed bits.
    always_comb begin
        result   = {a[SIZE-1], a} + {b[SIZE-1], b};
        overflow = result[SIZE] ^ result[SIZE-1];
    end
endmodule

module adder_arbiter #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [SIZE:0]   rsp_result,
    output logic            rsp_overflow,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state, state_next;
    logic            owner;
    logic            grant;
    logic            accept;
    logic            rsp_accept;
    logic [SIZE-1:0] op_a, op_b;
    logic [SIZE:0]   sum;
    logic            sum_ovf;
`ifndef ADDER_ARB_FIXED_PRIO_EN
    logic            last_grant;
`endif

    signed_adder #(.SIZE(SIZE)) u_adder (
        .a        (op_a),
        .b        (op_b),
        .result   (sum),
        .overflow (sum_ovf)
    );

    // grant selects requester 1 when set; only meaningful while IDLE.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        rsp_accept = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
        busy       = (state != IDLE);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    state_next = RESP;
            RESP:    if (rsp_accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                op_a  <= grant ? req1_a : req0_a;
                op_b  <= grant ? req1_b : req0_b;
                owner <= grant;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                last_grant <= grant;
`endif
            end
            if (state == CALC) begin
                rsp_result   <= sum;
                rsp_overflow <= sum_ovf;
                rsp0_valid   <= !owner;
                rsp1_valid   <= owner;
            end
            if (state == RESP && rsp_accept) begin
                rsp0_valid <= 1'b0;
                rsp1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter: reset, single request, arbitration, backpressure, signed arithmetic, reset mid-operation.

module tb_adder_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [8:0] rsp_result;
    logic       rsp_overflow;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    adder_arbiter #(.SIZE(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, 9-bit two's complement sum} of two signed bytes.
    function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b);
        int         s;
        logic [8:0] r;
        logic       o;
        s = $signed(a) + $signed(b);
        r = s[8:0];
        o = (s > 127) || (s < -128);
        return {o, r};
    endfunction

    // Both requesters valid, responses accepted immediately; g is the expected winner.
    task automatic rr_step(input logic g, input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1);
        logic [9:0] e;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        e = g ? ref_add(a1, b1) : ref_add(a0, b0);
        #1;
        check("rr_req0_ready", 16'(req0_ready), 16'(!g));
        check("rr_req1_ready", 16'(req1_ready), 16'(g));
        tick();
        tick();
        check("rr_rsp0_valid", 16'(rsp0_valid), 16'(!g));
        check("rr_rsp1_valid", 16'(rsp1_valid), 16'(g));
        check("rr_result", 16'(rsp_result), 16'(e[8:0]));
        check("rr_overflow", 16'(rsp_overflow), 16'(e[9]));
        tick();
        check("rr_idle", 16'(busy), 16'(0));
    endtask

    // Requester 0 alone; checks 2-cycle latency and bit-exact arithmetic.
    task automatic solo0(input logic [7:0] a, input logic [7:0] b);
        logic [9:0] e;
        e = ref_add(a, b);
        req0_a = a; req0_b = b; req0_valid = 1'b1; rsp0_ready = 1'b1;
        #1;
        check("solo_req0_ready", 16'(req0_ready), 16'(1));
        tick();
        req0_valid = 1'b0;
        tick();
        check("solo_rsp0_valid", 16'(rsp0_valid), 16'(1));
        check("solo_result", 16'(rsp_result), 16'(e[8:0]));
        check("solo_overflow", 16'(rsp_overflow), 16'(e[9]));
        tick();
        check("solo_idle", 16'(busy), 16'(0));
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        tick();
        check("rst_rsp0_valid", 16'(rsp0_valid), 16'(0));
        check("rst_rsp1_valid", 16'(rsp1_valid), 16'(0));
        check("rst_result", 16'(rsp_result), 16'(0));
        check("rst_overflow", 16'(rsp_overflow), 16'(0));
        check("rst_busy", 16'(busy), 16'(0));

        // Handshake offered while reset is asserted must not be captured.
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03;
        tick();
        check("rst_hs_busy", 16'(busy), 16'(0));

        // Single request: ready at cycle 1, response at cycle 3.
        rst = 1'b0;
        #1;
        check("single_req0_ready", 16'(req0_ready), 16'(1));
        check("single_req1_ready", 16'(req1_ready), 16'(0));
        tick();
        req0_valid = 1'b0;
        check("single_calc_busy", 16'(busy), 16'(1));
        check("single_calc_rsp0", 16'(rsp0_valid), 16'(0));
        tick();
        check("single_rsp0_valid", 16'(rsp0_valid), 16'(1));
        check("single_rsp1_valid", 16'(rsp1_valid), 16'(0));
        check("single_result", 16'(rsp_result), 16'h008);
        check("single_overflow", 16'(rsp_overflow), 16'(0));
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("single_done_rsp0", 16'(rsp0_valid), 16'(0));
        check("single_done_busy", 16'(busy), 16'(0));

        // Arbitration with both requesters continuously valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
`ifdef ADDER_ARB_FIXED_PRIO_EN
        rr_step(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        rr_step(1'b0, 8'h7F, 8'h7F, 8'h01, 8'h02);
        rr_step(1'b0, 8'hF0, 8'h05, 8'h80, 8'hFF);
        rr_step(1'b0, 8'h40, 8'h40, 8'hC0, 8'hC0);
`else
        rr_step(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        rr_step(1'b1, 8'h7F, 8'h7F, 8'h01, 8'h02);
        rr_step(1'b0, 8'hF0, 8'h05, 8'h80, 8'hFF);
        rr_step(1'b1, 8'h40, 8'h40, 8'hC0, 8'hC0);
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // Backpressure on requester 1 while requester 0 waits.
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20;
        #1;
        check("bp_req1_ready", 16'(req1_ready), 16'(1));
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        rsp0_ready = 1'b1;
        #1;
        check("bp_calc_req0_ready", 16'(req0_ready), 16'(0));
        tick();
        check("bp_rsp1_valid", 16'(rsp1_valid), 16'(1));
        check("bp_result", 16'(rsp_result), 16'h030);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_rsp1_valid", 16'(rsp1_valid), 16'(1));
            check("bp_hold_result", 16'(rsp_result), 16'h030);
            check("bp_hold_rsp0_valid", 16'(rsp0_valid), 16'(0));
            check("bp_hold_req0_ready", 16'(req0_ready), 16'(0));
        end
        rsp1_ready = 1'b1;
        #1;
        check("bp_accept_req0_ready", 16'(req0_ready), 16'(0));
        tick();
        rsp1_ready = 1'b0;
        check("bp_released_rsp1", 16'(rsp1_valid), 16'(0));
        check("bp_next_req0_ready", 16'(req0_ready), 16'(1));
        tick();
        req0_valid = 1'b0;
        tick();
        check("bp_rsp0_valid", 16'(rsp0_valid), 16'(1));
        check("bp_rsp0_result", 16'(rsp_result), 16'h003);
        tick();
        check("bp_idle", 16'(busy), 16'(0));

        // Signed arithmetic corner cases.
        solo0(8'hFE, 8'hFD);
        solo0(8'h7F, 8'h01);
        solo0(8'h80, 8'h80);
        rsp0_ready = 1'b0;

        // Reset during CALC drops the operation; requester 0 wins the next tie.
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h05;
        tick();
        req0_valid = 1'b0;
        check("midrst_calc_busy", 16'(busy), 16'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 16'(busy), 16'(0));
        check("midrst_rsp0_valid", 16'(rsp0_valid), 16'(0));
        check("midrst_result", 16'(rsp_result), 16'(0));
        tick();
        check("midrst_no_pulse", 16'(rsp0_valid | rsp1_valid), 16'(0));
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("midrst_req0_ready", 16'(req0_ready), 16'(1));
        check("midrst_req1_ready", 16'(req1_ready), 16'(0));
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("midrst_regrant_busy", 16'(busy), 16'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
